// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/response bundle between the EX stage and the mul/div unit.
//   flush_i, start_i, op_i, opdata1_i, opdata2_i : issued by the pipeline (master)
//   result_o, ready_o, busy_o, div_by_zero_o     : registered unit responses (slave)
//   stallreq_o                                   : combinational stall request (slave)
interface ex_muldiv_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      flush_i;
    logic                      start_i;
    logic [1:0]                op_i;
    logic [DATA_WIDTH-1:0]     opdata1_i;
    logic [DATA_WIDTH-1:0]     opdata2_i;
    logic [2*DATA_WIDTH-1:0]   result_o;
    logic                      ready_o;
    logic                      busy_o;
    logic                      div_by_zero_o;
    logic                      stallreq_o;

    modport master (
        output flush_i, start_i, op_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, div_by_zero_o, stallreq_o
    );

    modport slave (
        input  flush_i, start_i, op_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, div_by_zero_o, stallreq_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine for the execute stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ex_muldiv_if.slave (operands/op/start/flush in; {HI,LO} result,
//              ready pulse, busy, divide-by-zero flag and stall request out)
// Multiplier is a MUL_STAGES-deep product pipeline; divider is radix-2
// restoring on magnitudes with sign fix-up and an optional early-out.
module ex_muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned EARLY_OUT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned W2 = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_PREP, S_DIV_RUN, S_DIV_FIX, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            early_q, early_d;
    logic            sgn_q, sgn_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    abs_b_q, abs_b_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W2-1:0]   mul_pipe_q [MUL_STAGES];
    logic [W2-1:0]   mul_pipe_d [MUL_STAGES];
    logic [W2-1:0]   result_q, result_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic [W2-1:0]   mul_a_ext, mul_b_ext, mul_prod;
    logic            a_neg, b_neg;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      rem_sh;
    logic            rem_ge;
    logic [W-1:0]    fix_q, fix_r;

    // Datapath helpers: product of the incoming operands, magnitudes, one restoring step.
    always_comb begin
        accept    = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;
        mul_a_ext = {{W{~bus.op_i[0] & bus.opdata1_i[W-1]}}, bus.opdata1_i};
        mul_b_ext = {{W{~bus.op_i[0] & bus.opdata2_i[W-1]}}, bus.opdata2_i};
        mul_prod  = mul_a_ext * mul_b_ext;
        a_neg     = sgn_q & a_q[W-1];
        b_neg     = sgn_q & b_q[W-1];
        abs_a     = a_neg ? (~a_q + W'(1)) : a_q;
        abs_b     = b_neg ? (~b_q + W'(1)) : b_q;
        rem_sh    = {rem_q, quo_q[W-1]};
        rem_ge    = rem_sh >= {1'b0, abs_b_q};
        // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
        fix_q     = (a_neg ^ b_neg) ? (~quo_q + W'(1)) : quo_q;
        fix_r     = a_neg ? (~rem_q + W'(1)) : rem_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        early_d  = early_q;
        sgn_d    = sgn_q;
        a_d      = a_q;
        b_d      = b_q;
        abs_b_d  = abs_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        ready_d  = 1'b0;
        dbz_d    = 1'b0;

        // Product enters the pipe on accept; later stages always shift.
        mul_pipe_d[0] = accept ? mul_prod : mul_pipe_q[0];
        for (int unsigned i = 1; i < MUL_STAGES; i++) begin
            mul_pipe_d[i] = mul_pipe_q[i-1];
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = bus.opdata1_i;
                    b_d     = bus.opdata2_i;
                    sgn_d   = ~bus.op_i[0];
                    cnt_d   = '0;
                    state_d = bus.op_i[1] ? S_DIV_PREP : S_MUL;
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(MUL_STAGES - 1)) begin
                    result_d = mul_pipe_q[MUL_STAGES-1];
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV_PREP: begin
                if (b_q == '0) begin
                    result_d = {a_q, {W{1'b1}}};
                    ready_d  = 1'b1;
                    dbz_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    abs_b_d = abs_b;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    early_d = (EARLY_OUT != 0) && (abs_a < abs_b);
                    cnt_d   = '0;
                    state_d = S_DIV_RUN;
                end
            end
            S_DIV_RUN: begin
                if (early_q) begin
                    // |a| < |b|: quotient 0, remainder is the untouched dividend.
                    result_d = {a_q, W'(0)};
                    ready_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    rem_d = rem_ge ? (rem_sh[W-1:0] - abs_b_q) : rem_sh[W-1:0];
                    quo_d = {quo_q[W-2:0], rem_ge};
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = S_DIV_FIX;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DIV_FIX: begin
                result_d = {fix_r, fix_q};
                ready_d  = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush abandons the operation and keeps the last completed result.
        if (bus.flush_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            result_d = result_q;
            ready_d  = 1'b0;
            dbz_d    = 1'b0;
        end

        busy_d = (state_d == S_MUL) || (state_d == S_DIV_PREP) ||
                 (state_d == S_DIV_RUN) || (state_d == S_DIV_FIX);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            early_q  <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            early_q  <= early_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            dbz_q    <= dbz_d;
        end
    end

    // Operand and arithmetic datapath registers (no reset needed).
    always_ff @(posedge clk) begin
        a_q        <= a_d;
        b_q        <= b_d;
        abs_b_q    <= abs_b_d;
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        mul_pipe_q <= mul_pipe_d;
    end

    assign bus.result_o      = result_q;
    assign bus.ready_o       = ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.div_by_zero_o = dbz_q;
    assign bus.stallreq_o    = accept ||
                               (state_q == S_MUL) || (state_q == S_DIV_PREP) ||
                               (state_q == S_DIV_RUN) || (state_q == S_DIV_FIX);
endmodule
